// File: rtl/systolic_ctrl.sv
// Operand sequencer for an MATRIX_SIZE x MATRIX_SIZE output-stationary systolic array.
// Build option SYSTOLIC_CTRL_ACCUM_EN adds an accumulate input that skips the array clear.
module systolic_ctrl #(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int IDX_W       = $clog2(MATRIX_SIZE)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              a_wr_en,
  input  logic [IDX_W-1:0]                  a_wr_row,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] a_wr_data,
  input  logic                              b_wr_en,
  input  logic [IDX_W-1:0]                  b_wr_col,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] b_wr_data,
  input  logic                              start,
`ifdef SYSTOLIC_CTRL_ACCUM_EN
  input  logic                              accumulate,
`endif
  output logic                              busy,
  output logic                              done,
  output logic                              arr_rst,
  output logic                              arr_en,
  output logic [DATA_WIDTH-1:0]             arr_left [MATRIX_SIZE],
  output logic [DATA_WIDTH-1:0]             arr_top  [MATRIX_SIZE]
);

  localparam int N   = MATRIX_SIZE;
  localparam int T_W = $clog2(3 * N - 1);
  localparam logic [T_W-1:0] T_LAST = T_W'(3 * N - 3);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FEED, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [T_W-1:0]        t_q, t_d;
  logic [DATA_WIDTH-1:0] a_buf_q [N][N];
  logic [DATA_WIDTH-1:0] a_buf_d [N][N];
  logic [DATA_WIDTH-1:0] b_buf_q [N][N];
  logic [DATA_WIDTH-1:0] b_buf_d [N][N];
  logic [DATA_WIDTH-1:0] left_q  [N];
  logic [DATA_WIDTH-1:0] left_d  [N];
  logic [DATA_WIDTH-1:0] top_q   [N];
  logic [DATA_WIDTH-1:0] top_d   [N];
  logic                  busy_q, done_q, en_q;

  // a_buf holds A[i][k], b_buf holds B[k][j]; writes land only while idle
  always_comb begin
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    if (state_q == S_IDLE) begin
      if (a_wr_en) begin
        for (int k = 0; k < N; k++) a_buf_d[a_wr_row][k] = a_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (b_wr_en) begin
        for (int k = 0; k < N; k++) b_buf_d[k][b_wr_col] = b_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          t_d     = '0;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
          state_d = accumulate ? S_FEED : S_CLEAR;
`else
          state_d = S_CLEAR;
`endif
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        t_d     = '0;
      end
      S_FEED: begin
        if (t_q == T_LAST) state_d = S_DONE;
        else               t_d     = t_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Skewed operands for the next cycle: row i / column j lag by i / j cycles
  always_comb begin
    for (int i = 0; i < N; i++) begin
      left_d[i] = '0;
      top_d[i]  = '0;
      if (state_d == S_FEED && t_d >= T_W'(i) && (t_d - T_W'(i)) < T_W'(N)) begin
        left_d[i] = a_buf_d[i][IDX_W'(t_d - T_W'(i))];
        top_d[i]  = b_buf_d[IDX_W'(t_d - T_W'(i))][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      a_buf_q <= '{default: '0};
      b_buf_q <= '{default: '0};
      left_q  <= '{default: '0};
      top_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      en_q    <= (state_d == S_FEED);
      a_buf_q <= a_buf_d;
      b_buf_q <= b_buf_d;
      left_q  <= left_d;
      top_q   <= top_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign arr_en   = en_q;
  assign arr_rst  = rst | (state_q == S_CLEAR);
  assign arr_left = left_q;
  assign arr_top  = top_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: drives an ideal systolic array model from the DUT outputs and
// compares the result with a plain matrix product; also checks skew, timing and control.
module tb_systolic_ctrl;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            a_wr_en, b_wr_en, start;
  logic [IW-1:0]   a_wr_row, b_wr_col;
  logic [N*DW-1:0] a_wr_data, b_wr_data;
  logic            busy, done, arr_rst, arr_en;
  logic [DW-1:0]   arr_left [N];
  logic [DW-1:0]   arr_top  [N];
`ifdef SYSTOLIC_CTRL_ACCUM_EN
  logic            accumulate;
`endif

  int total = 0;
  int bad   = 0;
  int ref_a [N][N];
  int ref_b [N][N];
  int exp_c [N][N];
  int arr_acc [N][N];
  int a_pipe  [N][N];
  int b_pipe  [N][N];
  int done_cycle, done_cnt, busy_cnt, en_cnt, skew_err, busy_after_rst;
  int obs_left2 [3*N-2];

  systolic_ctrl #(.MATRIX_SIZE(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .a_wr_en(a_wr_en), .a_wr_row(a_wr_row), .a_wr_data(a_wr_data),
    .b_wr_en(b_wr_en), .b_wr_col(b_wr_col), .b_wr_data(b_wr_data),
    .start(start),
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    .accumulate(accumulate),
`endif
    .busy(busy), .done(done), .arr_rst(arr_rst), .arr_en(arr_en),
    .arr_left(arr_left), .arr_top(arr_top)
  );

  always #5 clk = ~clk;

  // Ideal output-stationary array: A flows right, B flows down, each PE accumulates a*b
  always @(posedge clk) begin
    int a_in, b_in;
    if (arr_rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          arr_acc[i][j] <= 0; a_pipe[i][j] <= 0; b_pipe[i][j] <= 0;
        end
    end else if (arr_en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (j == 0) a_in = int'(arr_left[i]); else a_in = a_pipe[i][j-1];
          if (i == 0) b_in = int'(arr_top[j]);  else b_in = b_pipe[i-1][j];
          arr_acc[i][j] <= arr_acc[i][j] + a_in * b_in;
          a_pipe[i][j]  <= a_in;
          b_pipe[i][j]  <= b_in;
        end
    end
  end

  function automatic void calc_ref();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_c[i][j] = 0;
        for (int k = 0; k < N; k++) exp_c[i][j] += ref_a[i][k] * ref_b[k][j];
      end
  endfunction

  function automatic void fill_ref(input int av, input int bv, input bit rnd);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ref_a[i][j] = rnd ? int'($urandom_range(0, 255)) : av;
        ref_b[i][j] = rnd ? int'($urandom_range(0, 255)) : bv;
      end
  endfunction

  task automatic load_mats();
    for (int i = 0; i < N; i++) begin
      a_wr_en = 1'b1; a_wr_row = IW'(i);
      b_wr_en = 1'b1; b_wr_col = IW'(i);
      for (int k = 0; k < N; k++) begin
        a_wr_data[k*DW +: DW] = DW'(ref_a[i][k]);
        b_wr_data[k*DW +: DW] = DW'(ref_b[k][i]);
      end
      @(posedge clk); #1;
    end
    a_wr_en = 1'b0; b_wr_en = 1'b0;
  endtask

  // Starts one operation and observes a fixed 20-cycle window; cycle 1 is the one after the start edge
  task automatic run_op(input bit accum, input bit poke, input int rst_cycle);
    int ff, tt, el, et;
    bit live, feed;
    ff = accum ? 1 : 2;
    done_cycle = -1; done_cnt = 0; busy_cnt = 0; en_cnt = 0; skew_err = 0; busy_after_rst = -1;
    for (int i = 0; i < 3*N-2; i++) obs_left2[i] = -1;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    accumulate = accum;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    accumulate = 1'b0;
`endif
    for (int cyc = 1; cyc <= 20; cyc++) begin
      live = (rst_cycle == 0) || (cyc <= rst_cycle);
      tt   = cyc - ff;
      feed = live && tt >= 0 && tt <= 3*N-3;
      if (busy === 1'b1) busy_cnt++;
      if (arr_en === 1'b1) en_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = cyc;
      end
      if (rst_cycle != 0 && cyc == rst_cycle + 1) busy_after_rst = (busy === 1'b1) ? 1 : 0;
      if (arr_en !== feed) skew_err++;
      for (int i = 0; i < N; i++) begin
        el = 0; et = 0;
        if (feed && tt - i >= 0 && tt - i < N) begin
          el = ref_a[i][tt-i];
          et = ref_b[tt-i][i];
        end
        if (arr_left[i] !== DW'(el)) skew_err++;
        if (arr_top[i]  !== DW'(et)) skew_err++;
      end
      if (feed) obs_left2[tt] = int'(arr_left[2]);
      if (poke && cyc == 5) begin
        start = 1'b1; a_wr_en = 1'b1; a_wr_row = '0; a_wr_data = {N{8'd99}};
      end
      if (cyc == rst_cycle) rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a_wr_en = 1'b0; rst = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (arr_en !== 1'b0)  begin bad++; $display("FAIL rst_en: got %b want 0", arr_en); end
    total++; if (arr_rst !== 1'b1) begin bad++; $display("FAIL rst_arr_rst: got %b want 1", arr_rst); end
    for (int i = 0; i < N; i++) begin
      total++;
      if (arr_left[i] !== '0 || arr_top[i] !== '0)
        begin bad++; $display("FAIL rst_operands[%0d]: got %0d/%0d want 0/0", i, arr_left[i], arr_top[i]); end
    end
    rst = 1'b0; #1;
    total++; if (arr_rst !== 1'b0) begin bad++; $display("FAIL idle_arr_rst: got %b want 0", arr_rst); end
    // buffers must be wiped by reset
    fill_ref(0, 0, 1'b1);
    load_mats();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    fill_ref(0, 0, 1'b0);
    run_op(1'b0, 1'b0, 0);
    total++; if (skew_err !== 0) begin bad++; $display("FAIL rst_cleared_operands: got %0d errors want 0", skew_err); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        total++;
        if (arr_acc[i][j] !== 0) begin bad++; $display("FAIL rst_cleared_acc[%0d][%0d]: got %0d want 0", i, j, arr_acc[i][j]); end
      end
  endtask

  task automatic test_identity();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ref_a[i][j] = (i == j) ? 1 : 0;
        ref_b[i][j] = 4*i + j + 1;
      end
    load_mats();
    run_op(1'b0, 1'b0, 0);
    total++; if (done_cycle !== 12) begin bad++; $display("FAIL ident_done_cycle: got %0d want 12", done_cycle); end
    total++; if (done_cnt !== 1)    begin bad++; $display("FAIL ident_done_cnt: got %0d want 1", done_cnt); end
    total++; if (busy_cnt !== 12)   begin bad++; $display("FAIL ident_busy_cnt: got %0d want 12", busy_cnt); end
    total++; if (en_cnt !== 10)     begin bad++; $display("FAIL ident_en_cnt: got %0d want 10", en_cnt); end
    total++; if (skew_err !== 0)    begin bad++; $display("FAIL ident_skew: got %0d errors want 0", skew_err); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        total++;
        if (arr_acc[i][j] !== 4*i + j + 1)
          begin bad++; $display("FAIL ident_acc[%0d][%0d]: got %0d want %0d", i, j, arr_acc[i][j], 4*i + j + 1); end
      end
  endtask

  task automatic test_patterns();
    for (int p = 0; p < 5; p++) begin
      if (p == 0)      fill_ref(2, 3, 1'b0);
      else if (p == 1) fill_ref(255, 255, 1'b0);
      else             fill_ref(0, 0, 1'b1);
      calc_ref();
      load_mats();
      run_op(1'b0, 1'b0, 0);
      total++; if (done_cycle !== 12) begin bad++; $display("FAIL pat%0d_done_cycle: got %0d want 12", p, done_cycle); end
      total++; if (skew_err !== 0)    begin bad++; $display("FAIL pat%0d_skew: got %0d errors want 0", p, skew_err); end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          total++;
          if (arr_acc[i][j] !== exp_c[i][j])
            begin bad++; $display("FAIL pat%0d_acc[%0d][%0d]: got %0d want %0d", p, i, j, arr_acc[i][j], exp_c[i][j]); end
        end
    end
    // fixed pattern results cross-checked against hand-computed constants
    fill_ref(2, 3, 1'b0); load_mats(); run_op(1'b0, 1'b0, 0);
    total++; if (arr_acc[1][2] !== 24) begin bad++; $display("FAIL pat_const24: got %0d want 24", arr_acc[1][2]); end
    fill_ref(255, 255, 1'b0); load_mats(); run_op(1'b0, 1'b0, 0);
    total++; if (arr_acc[3][0] !== 260100) begin bad++; $display("FAIL pat_const260100: got %0d want 260100", arr_acc[3][0]); end
  endtask

  task automatic test_skew();
    int exp_l2 [3*N-2] = '{0, 0, 10, 11, 12, 13, 0, 0, 0, 0};
    fill_ref(0, 0, 1'b1);
    for (int k = 0; k < N; k++) ref_a[2][k] = 10 + k;
    load_mats();
    run_op(1'b0, 1'b0, 0);
    for (int t = 0; t < 3*N-2; t++) begin
      total++;
      if (obs_left2[t] !== exp_l2[t])
        begin bad++; $display("FAIL skew_left2_t%0d: got %0d want %0d", t, obs_left2[t], exp_l2[t]); end
    end
    total++; if (en_cnt !== 10)  begin bad++; $display("FAIL skew_en_cnt: got %0d want 10", en_cnt); end
    total++; if (skew_err !== 0) begin bad++; $display("FAIL skew_all: got %0d errors want 0", skew_err); end
  endtask

  task automatic test_busy_ignore();
    fill_ref(0, 0, 1'b1);
    calc_ref();
    load_mats();
    run_op(1'b0, 1'b1, 0);
    total++; if (done_cnt !== 1)    begin bad++; $display("FAIL busy_done_cnt: got %0d want 1", done_cnt); end
    total++; if (done_cycle !== 12) begin bad++; $display("FAIL busy_done_cycle: got %0d want 12", done_cycle); end
    total++; if (busy_cnt !== 12)   begin bad++; $display("FAIL busy_busy_cnt: got %0d want 12", busy_cnt); end
    total++; if (skew_err !== 0)    begin bad++; $display("FAIL busy_skew: got %0d errors want 0", skew_err); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        total++;
        if (arr_acc[i][j] !== exp_c[i][j])
          begin bad++; $display("FAIL busy_acc[%0d][%0d]: got %0d want %0d", i, j, arr_acc[i][j], exp_c[i][j]); end
      end
  endtask

  task automatic test_reset_mid();
    fill_ref(0, 0, 1'b1);
    for (int i = 0; i < N; i++) ref_a[i][0] = 1 + i;
    load_mats();
    run_op(1'b0, 1'b0, 7);
    total++; if (busy_after_rst !== 0) begin bad++; $display("FAIL midrst_busy: got %0d want 0", busy_after_rst); end
    total++; if (done_cnt !== 0)       begin bad++; $display("FAIL midrst_done_cnt: got %0d want 0", done_cnt); end
    total++; if (skew_err !== 0)       begin bad++; $display("FAIL midrst_skew: got %0d errors want 0", skew_err); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        total++;
        if (arr_acc[i][j] !== 0) begin bad++; $display("FAIL midrst_acc[%0d][%0d]: got %0d want 0", i, j, arr_acc[i][j]); end
      end
    fill_ref(0, 0, 1'b1);
    calc_ref();
    load_mats();
    run_op(1'b0, 1'b0, 0);
    total++; if (done_cycle !== 12) begin bad++; $display("FAIL midrst_fresh_done: got %0d want 12", done_cycle); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        total++;
        if (arr_acc[i][j] !== exp_c[i][j])
          begin bad++; $display("FAIL midrst_fresh_acc[%0d][%0d]: got %0d want %0d", i, j, arr_acc[i][j], exp_c[i][j]); end
      end
  endtask

`ifdef SYSTOLIC_CTRL_ACCUM_EN
  task automatic test_accum();
    fill_ref(1, 1, 1'b0);
    load_mats();
    run_op(1'b0, 1'b0, 0);
    total++; if (arr_acc[0][0] !== 4 || arr_acc[3][3] !== 4)
      begin bad++; $display("FAIL accum_first: got %0d/%0d want 4/4", arr_acc[0][0], arr_acc[3][3]); end
    run_op(1'b1, 1'b0, 0);
    total++; if (done_cycle !== 11) begin bad++; $display("FAIL accum_done_cycle: got %0d want 11", done_cycle); end
    total++; if (busy_cnt !== 11)   begin bad++; $display("FAIL accum_busy_cnt: got %0d want 11", busy_cnt); end
    total++; if (en_cnt !== 10)     begin bad++; $display("FAIL accum_en_cnt: got %0d want 10", en_cnt); end
    total++; if (skew_err !== 0)    begin bad++; $display("FAIL accum_skew: got %0d errors want 0", skew_err); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        total++;
        if (arr_acc[i][j] !== 8) begin bad++; $display("FAIL accum_acc[%0d][%0d]: got %0d want 8", i, j, arr_acc[i][j]); end
      end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0;
    a_wr_en = 1'b0; a_wr_row = '0; a_wr_data = '0;
    b_wr_en = 1'b0; b_wr_col = '0; b_wr_data = '0;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    accumulate = 1'b0;
`endif
    test_reset();
    test_identity();
    test_patterns();
    test_skew();
    test_busy_ignore();
    test_reset_mid();
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    test_accum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
